// File: rtl/io_input_scan.sv
// rtl/io_input_scan.sv - scheduled sampler/debouncer for two 32-bit CPU input ports
// A divider tick walks a scan FSM over both ports; accepted values raise change flags and irq.
module io_input_scan #(
    parameter int SCAN_DIV = 4,
    parameter int DEB_LEN  = 3
) (
    input  logic        io_clk,
    input  logic        resetn,
    input  logic [31:0] in_port0,
    input  logic [31:0] in_port1,
    input  logic [31:0] addr,
    input  logic        io_rd,
    output logic [31:0] io_read_data,
    output logic        irq
);

    localparam int TW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEB_LEN + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEB_LEN);
    localparam logic [CW-1:0] CNT_ACC   = CW'(DEB_LEN - 1);
    localparam logic [5:0]    A_STABLE0 = 6'h20;
    localparam logic [5:0]    A_STABLE1 = 6'h21;
    localparam logic [5:0]    A_STATUS  = 6'h22;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_S0,
        ST_S1
    } state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
    logic [1:0][31:0]   cand_q, cand_d;
    logic [1:0][31:0]   stable_q, stable_d;
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    logic [1:0]         chg_q, chg_d;
    logic               irq_q, irq_d;

    logic               tick;
    logic               status_clr;
    logic [1:0][31:0]   sample;
    logic [1:0]         slot;
    logic [1:0]         chg_set;
    logic               unused_addr;

    assign unused_addr = ^{addr[31:8], addr[1:0]};
    assign tick        = (tick_cnt_q == TICK_LAST);
    assign status_clr  = io_rd && (addr[7:2] == A_STATUS);
    assign sample      = {in_port1, in_port0};
    assign slot        = {state_q == ST_S1, state_q == ST_S0};

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        state_d    = state_q;
        case (state_q)
            ST_IDLE: if (tick) state_d = ST_S0;
            ST_S0:   state_d = ST_S1;
            ST_S1:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Each port only moves in its own scan slot; outside it cand/cnt/stable hold.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        chg_set  = '0;
        for (int p = 0; p < 2; p++) begin
            if (slot[p]) begin
                if (sample[p] != cand_q[p]) begin
                    cand_d[p] = sample[p];
                    cnt_d[p]  = CW'(1);
                end else begin
                    if (cnt_q[p] < CNT_MAX) begin
                        cnt_d[p] = cnt_q[p] + CW'(1);
                    end
                    if ((cnt_q[p] == CNT_ACC) && (cand_q[p] != stable_q[p])) begin
                        stable_d[p] = cand_q[p];
                        chg_set[p]  = 1'b1;
                    end
                end
            end
        end
        // A new acceptance outranks a status-read clear in the same cycle.
        chg_d = chg_set | (chg_q & {2{~status_clr}});
        irq_d = |chg_q;
    end

    always_comb begin
        io_read_data = 32'h0;
        case (addr[7:2])
            A_STABLE0: io_read_data = stable_q[0];
            A_STABLE1: io_read_data = stable_q[1];
            A_STATUS:  io_read_data = {30'b0, chg_q};
            default:   io_read_data = 32'h0;
        endcase
    end

    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            cand_q     <= '0;
            cnt_q      <= '0;
            stable_q   <= '0;
            chg_q      <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            stable_q   <= stable_d;
            chg_q      <= chg_d;
            irq_q      <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_io_input_scan.sv
// tb/tb_io_input_scan.sv - directed scoreboard bench for io_input_scan
module tb_io_input_scan;

    logic        io_clk = 1'b0;
    logic        resetn;
    logic [31:0] in_port0;
    logic [31:0] in_port1;
    logic [31:0] addr;
    logic        io_rd;
    logic [31:0] io_read_data;
    logic        irq;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [31:0] exp_q[$];

    localparam logic [31:0] A_ST0 = 32'h80;
    localparam logic [31:0] A_ST1 = 32'h84;
    localparam logic [31:0] A_STS = 32'h88;

    io_input_scan #(.SCAN_DIV(4), .DEB_LEN(3)) dut (
        .io_clk      (io_clk),
        .resetn      (resetn),
        .in_port0    (in_port0),
        .in_port1    (in_port1),
        .addr        (addr),
        .io_rd       (io_rd),
        .io_read_data(io_read_data),
        .irq         (irq)
    );

    always #5 io_clk = ~io_clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step_to(input int n);
        while (cyc < n) begin
            @(posedge io_clk);
            #1;
            cyc++;
        end
    endtask

    task automatic push_exp(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic compare(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, e);
            end
        end
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] e);
        push_exp(e);
        addr = a;
        #1;
        compare(tag, io_read_data);
    endtask

    task automatic chk_irq(input string tag, input logic e);
        push_exp({31'b0, e});
        compare(tag, {31'b0, irq});
    endtask

    initial begin
        resetn   = 1'b0;
        in_port0 = 32'h0;
        in_port1 = 32'h0;
        addr     = 32'h0;
        io_rd    = 1'b0;
        repeat (3) @(posedge io_clk);
        #1;
        rd("rst_stable0", A_ST0, 32'h0);
        rd("rst_stable1", A_ST1, 32'h0);
        rd("rst_status", A_STS, 32'h0);
        chk_irq("rst_irq", 1'b0);
        @(posedge io_clk);
        #1;
        resetn = 1'b1;
        cyc    = 0;

        // Idle ports read back zero, unmapped addresses read zero, irq never rises.
        step_to(3);
        rd("idle_stable0", A_ST0, 32'h0);
        rd("idle_stable1", A_ST1, 32'h0);
        rd("idle_status", A_STS, 32'h0);
        rd("unmapped_8c", 32'h8C, 32'h0);
        rd("unmapped_00", 32'h00, 32'h0);
        for (int n = 4; n <= 11; n++) begin
            step_to(n);
            rd("idle_status_loop", A_STS, 32'h0);
            chk_irq("idle_irq_loop", 1'b0);
        end

        // Port0 steady value: accepted on the third matching S0 sample.
        step_to(12);
        in_port0 = 32'hA5A5_0001;
        for (int n = 13; n <= 20; n++) begin
            step_to(n);
            rd("p0_not_yet", A_ST0, 32'h0);
        end
        step_to(21);
        rd("p0_accepted", A_ST0, 32'hA5A5_0001);
        rd("p0_chg_set", A_STS, 32'h1);
        chk_irq("p0_irq_lag", 1'b0);
        step_to(22);
        chk_irq("p0_irq_high", 1'b1);
        io_rd = 1'b1;
        rd("p0_clear_read", A_STS, 32'h1);
        step_to(23);
        io_rd = 1'b0;
        rd("p0_reread", A_STS, 32'h0);
        chk_irq("p0_irq_tail", 1'b1);
        step_to(24);
        chk_irq("p0_irq_drop", 1'b0);

        // 5-cycle glitch on port1 spans two samples but is never accepted.
        for (int n = 25; n <= 44; n++) begin
            step_to(n);
            if (n == 25) in_port1 = 32'h0000_FFFF;
            if (n == 30) in_port1 = 32'h0;
            rd("glitch_stable1", A_ST1, 32'h0);
            rd("glitch_status", A_STS, 32'h0);
            chk_irq("glitch_irq", 1'b0);
        end

        // Both ports change within one tick: port0 lands one cycle before port1.
        in_port0 = 32'h1234_5678;
        in_port1 = 32'hDEAD_BEEF;
        step_to(52);
        rd("both_old0", A_ST0, 32'hA5A5_0001);
        rd("both_old1", A_ST1, 32'h0);
        step_to(53);
        rd("both_new0", A_ST0, 32'h1234_5678);
        rd("both_wait1", A_ST1, 32'h0);
        rd("both_sts1", A_STS, 32'h1);
        step_to(54);
        rd("both_new1", A_ST1, 32'hDEAD_BEEF);
        rd("both_sts3", A_STS, 32'h3);
        chk_irq("both_irq", 1'b1);
        step_to(55);
        io_rd = 1'b1;
        rd("both_clear", A_STS, 32'h3);
        step_to(56);
        io_rd = 1'b0;
        rd("both_cleared", A_STS, 32'h0);
        chk_irq("both_irq_tail", 1'b1);

        // Status read lands in the S1 cycle that accepts port1: set beats clear.
        in_port0 = 32'h0000_00F0;
        in_port1 = 32'h0F0F_0F0F;
        step_to(57);
        chk_irq("race_irq_low", 1'b0);
        step_to(65);
        rd("race_new0", A_ST0, 32'h0000_00F0);
        chk_irq("race_irq_pre", 1'b0);
        io_rd = 1'b1;
        rd("race_read", A_STS, 32'h1);
        step_to(66);
        io_rd = 1'b0;
        rd("race_after", A_STS, 32'h2);
        rd("race_new1", A_ST1, 32'h0F0F_0F0F);
        chk_irq("race_irq_a", 1'b1);
        step_to(67);
        chk_irq("race_irq_b", 1'b1);
        io_rd = 1'b1;
        rd("race_clear", A_STS, 32'h2);
        step_to(68);
        io_rd = 1'b0;
        rd("race_cleared", A_STS, 32'h0);

        // Reset during S0 with cnt_0=2 discards the partial debounce.
        in_port0 = 32'h5555_AAAA;
        step_to(76);
        resetn   = 1'b0;
        in_port1 = 32'h0;
        rd("mid_rst_stable0", A_ST0, 32'h0);
        rd("mid_rst_stable1", A_ST1, 32'h0);
        rd("mid_rst_status", A_STS, 32'h0);
        chk_irq("mid_rst_irq", 1'b0);
        @(posedge io_clk);
        #1;
        chk_irq("mid_rst_irq_hold", 1'b0);
        @(posedge io_clk);
        #1;
        resetn = 1'b1;
        cyc    = 0;
        for (int n = 1; n <= 12; n++) begin
            step_to(n);
            rd("post_rst_wait0", A_ST0, 32'h0);
            chk_irq("post_rst_irq", 1'b0);
        end
        step_to(13);
        rd("post_rst_accept0", A_ST0, 32'h5555_AAAA);
        rd("post_rst_sts", A_STS, 32'h1);
        step_to(14);
        chk_irq("post_rst_irq_high", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
